// File: rtl/smi_access_arbiter.sv
// Round-robin arbiter sharing one SMI/MDIO engine between NREQ requesters.
// Each granted transaction runs to completion (or timeout) before the next grant.
module smi_access_arbiter #(
  parameter int NREQ        = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk_100m,
  input  logic                 rst_100m,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [5*NREQ-1:0]    req_phy,
  input  logic [5*NREQ-1:0]    req_reg,
  input  logic [16*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 smi_wract,
  output logic                 smi_rdact,
  output logic [15:0]          smi_wdata,
  output logic [4:0]           smi_dev_addr,
  output logic [4:0]           smi_phy_addr,
  input  logic                 smi_busy,
  input  logic [15:0]          smi_rdata,
  input  logic                 smi_rdval
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WR_WAIT_HI, WR_WAIT_LO, RD_WAIT, DONE} state_t;

  state_t          state_r;
  logic [IW-1:0]   last_gnt_r;
  logic [IW-1:0]   owner_r;
  logic            wr_r;
  logic [4:0]      phy_r;
  logic [4:0]      reg_r;
  logic [15:0]     wdata_r;
  logic [15:0]     rdata_r;
  logic            err_r;
  logic [15:0]     tmo_cnt_r;
  logic            busy_q_r;

  logic [IW-1:0]   gnt_idx_s;
  logic            gnt_found_s;
  logic            take_s;
  int              cand_s;
  logic            tmo_hit_s;
  logic [NREQ-1:0] one_s;
  logic [4:0]      phy_a_s   [NREQ];
  logic [4:0]      reg_a_s   [NREQ];
  logic [15:0]     wdata_a_s [NREQ];

  assign tmo_hit_s = (tmo_cnt_r == 16'(TIMEOUT_CYC));
  assign one_s     = {{(NREQ-1){1'b0}}, 1'b1};

  // Unpack the per-requester request fields into indexable arrays.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      phy_a_s[i]   = req_phy[5*i +: 5];
      reg_a_s[i]   = req_reg[5*i +: 5];
      wdata_a_s[i] = req_wdata[16*i +: 16];
    end
  end

  // Round-robin search upward from the requester after the last grant.
  always_comb begin
    gnt_idx_s   = '0;
    gnt_found_s = 1'b0;
    take_s      = 1'b0;
    cand_s      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s      = (int'(last_gnt_r) + k) % NREQ;
      take_s      = !gnt_found_s && req_valid[IW'(cand_s)];
      gnt_idx_s   = take_s ? IW'(cand_s) : gnt_idx_s;
      gnt_found_s = gnt_found_s | take_s;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      state_r      <= IDLE;
      last_gnt_r   <= IW'(NREQ-1);
      owner_r      <= '0;
      wr_r         <= 1'b0;
      phy_r        <= 5'd0;
      reg_r        <= 5'd0;
      wdata_r      <= 16'h0000;
      rdata_r      <= 16'h0000;
      err_r        <= 1'b0;
      tmo_cnt_r    <= 16'h0000;
      busy_q_r     <= 1'b0;
      req_ack      <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= 16'h0000;
      rsp_err      <= 1'b0;
      smi_wract    <= 1'b0;
      smi_rdact    <= 1'b0;
      smi_wdata    <= 16'h0000;
      smi_dev_addr <= 5'd0;
      smi_phy_addr <= 5'd0;
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= 16'h0000;
      rsp_err   <= 1'b0;
      smi_wract <= 1'b0;
      // One extra cycle of guard after the engine goes idle before a new grant.
      busy_q_r  <= smi_busy;
      case (state_r)
        IDLE: begin
          if (!smi_busy && !busy_q_r && gnt_found_s) begin
            req_ack    <= one_s << gnt_idx_s;
            owner_r    <= gnt_idx_s;
            last_gnt_r <= gnt_idx_s;
            wr_r       <= req_wr[gnt_idx_s];
            phy_r      <= phy_a_s[gnt_idx_s];
            reg_r      <= reg_a_s[gnt_idx_s];
            wdata_r    <= req_wr[gnt_idx_s] ? wdata_a_s[gnt_idx_s] : 16'h0000;
            rdata_r    <= 16'h0000;
            err_r      <= 1'b0;
            tmo_cnt_r  <= 16'h0000;
            state_r    <= ISSUE;
          end
        end
        ISSUE: begin
          smi_phy_addr <= phy_r;
          smi_dev_addr <= reg_r;
          smi_wdata    <= wdata_r;
          if (wr_r) begin
            smi_wract <= 1'b1;
            state_r   <= WR_WAIT_HI;
          end else begin
            smi_rdact <= 1'b1;
            state_r   <= RD_WAIT;
          end
        end
        WR_WAIT_HI, WR_WAIT_LO: begin
          if (tmo_hit_s) begin
            err_r   <= 1'b1;
            state_r <= DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
            if (state_r == WR_WAIT_HI && smi_busy) begin
              state_r <= WR_WAIT_LO;
            end else if (state_r == WR_WAIT_LO && !smi_busy) begin
              state_r <= DONE;
            end
          end
        end
        RD_WAIT: begin
          if (smi_rdval) begin
            rdata_r   <= smi_rdata;
            smi_rdact <= 1'b0;
            state_r   <= DONE;
          end else if (tmo_hit_s) begin
            rdata_r   <= 16'h0000;
            err_r     <= 1'b1;
            smi_rdact <= 1'b0;
            state_r   <= DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end
        end
        DONE: begin
          rsp_valid    <= one_s << owner_r;
          rsp_rdata    <= rdata_r;
          rsp_err      <= err_r;
          smi_wdata    <= 16'h0000;
          smi_dev_addr <= 5'd0;
          smi_phy_addr <= 5'd0;
          state_r      <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smi_access_arbiter.sv
// Directed bench for smi_access_arbiter: read, write, rotation, busy, timeout, reset.
module tb_smi_access_arbiter;

  localparam int NREQ = 3;

  logic              clk_100m = 1'b0;
  logic              rst_100m;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_wr;
  logic [5*NREQ-1:0] req_phy;
  logic [5*NREQ-1:0] req_reg;
  logic [16*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              rsp_err;
  logic              smi_wract;
  logic              smi_rdact;
  logic [15:0]       smi_wdata;
  logic [4:0]        smi_dev_addr;
  logic [4:0]        smi_phy_addr;
  logic              smi_busy;
  logic [15:0]       smi_rdata;
  logic              smi_rdval;

  int checks = 0;
  int errors = 0;

  smi_access_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(100)) dut (
    .clk_100m(clk_100m), .rst_100m(rst_100m),
    .req_valid(req_valid), .req_wr(req_wr), .req_phy(req_phy), .req_reg(req_reg),
    .req_wdata(req_wdata), .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .smi_wract(smi_wract),
    .smi_rdact(smi_rdact), .smi_wdata(smi_wdata), .smi_dev_addr(smi_dev_addr),
    .smi_phy_addr(smi_phy_addr), .smi_busy(smi_busy), .smi_rdata(smi_rdata),
    .smi_rdval(smi_rdval)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts right after the req_ack cycle of a read; engine answers at once.
  task automatic finish_read(input int idx, input logic [15:0] data);
    tick();
    chk("rd_rdact_hi", {63'd0, smi_rdact}, 64'd1);
    smi_rdata = data;
    smi_rdval = 1'b1;
    tick();
    chk("rd_rdact_lo", {63'd0, smi_rdact}, 64'd0);
    smi_rdval = 1'b0;
    smi_rdata = 16'h0000;
    tick();
    chk("rd_rsp_valid", {61'd0, rsp_valid}, 64'd1 << idx);
    chk("rd_rsp_rdata", {48'd0, rsp_rdata}, {48'd0, data});
    chk("rd_rsp_err", {63'd0, rsp_err}, 64'd0);
  endtask

  initial begin
    int bad;
    rst_100m = 1'b1; req_valid = '0; req_wr = '0; req_phy = '0; req_reg = '0;
    req_wdata = '0; smi_busy = 1'b0; smi_rdata = 16'h0000; smi_rdval = 1'b0;
    tick(); tick(); tick();
    chk("reset_outputs", {13'd0, req_ack, rsp_valid, rsp_rdata, rsp_err, smi_wract,
        smi_rdact, smi_wdata, smi_dev_addr, smi_phy_addr}, 64'd0);
    rst_100m = 1'b0;

    // Single read by requester 1, engine answers 40 cycles into the wait.
    req_valid = 3'b010; req_wr = 3'b000; req_phy[9:5] = 5'd2; req_reg[9:5] = 5'h1f;
    tick();
    chk("read_ack", {61'd0, req_ack}, 64'b010);
    req_valid = 3'b000;
    tick();
    chk("read_ack_once", {61'd0, req_ack}, 64'd0);
    chk("read_rdact", {63'd0, smi_rdact}, 64'd1);
    chk("read_phy", {59'd0, smi_phy_addr}, 64'd2);
    chk("read_reg", {59'd0, smi_dev_addr}, 64'h1f);
    bad = 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (smi_rdact !== 1'b1 || rsp_valid !== 3'b000) bad++;
    end
    chk("read_rdact_held", bad, 64'd0);
    smi_rdata = 16'h0010; smi_rdval = 1'b1;
    tick();
    chk("read_rdact_drop", {63'd0, smi_rdact}, 64'd0);
    smi_rdval = 1'b0; smi_rdata = 16'h0000;
    tick();
    chk("read_rsp_valid", {61'd0, rsp_valid}, 64'b010);
    chk("read_rsp_rdata", {48'd0, rsp_rdata}, 64'h0010);
    chk("read_rsp_err", {63'd0, rsp_err}, 64'd0);
    tick();
    chk("read_rsp_pulse", {61'd0, rsp_valid}, 64'd0);

    // Write handshake by requester 0.
    req_valid = 3'b001; req_wr = 3'b001; req_phy[4:0] = 5'd0; req_reg[4:0] = 5'd0;
    req_wdata[15:0] = 16'h9140;
    tick();
    chk("write_ack", {61'd0, req_ack}, 64'b001);
    req_valid = 3'b000; req_wdata[15:0] = 16'h0000;
    tick();
    chk("write_wract", {63'd0, smi_wract}, 64'd1);
    chk("write_wdata", {48'd0, smi_wdata}, 64'h9140);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (smi_wract !== 1'b0 || rsp_valid !== 3'b000) bad++;
    end
    smi_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (smi_wract !== 1'b0 || rsp_valid !== 3'b000) bad++;
    end
    chk("write_wait_busy", bad, 64'd0);
    smi_busy = 1'b0;
    tick();
    chk("write_no_early_rsp", {61'd0, rsp_valid}, 64'd0);
    tick();
    chk("write_rsp_valid", {61'd0, rsp_valid}, 64'b001);
    chk("write_rsp_rdata", {48'd0, rsp_rdata}, 64'd0);
    req_wr = 3'b000;

    // Round-robin with all requesters held valid from reset.
    rst_100m = 1'b1; req_valid = 3'b111;
    tick(); tick();
    rst_100m = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_grant", {61'd0, req_ack}, 64'd1 << (i % 3));
      chk("rr_no_overlap", {61'd0, rsp_valid}, 64'd0);
      finish_read(i % 3, 16'hA000 + 16'(i));
    end
    req_valid = 3'b000;

    // Busy blocking: requester 2 waits until the engine goes idle.
    smi_busy = 1'b1; req_valid = 3'b100;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req_ack !== 3'b000) bad++;
    end
    chk("busy_no_ack", bad, 64'd0);
    smi_busy = 1'b0;
    tick();
    chk("busy_guard", {61'd0, req_ack}, 64'd0);
    tick();
    chk("busy_grant", {61'd0, req_ack}, 64'b100);
    req_valid = 3'b000;
    finish_read(2, 16'h5a5a);

    // Timeout: requester 0 reads, engine never answers.
    req_valid = 3'b001; smi_rdata = 16'hdead;
    tick();
    chk("tmo_ack", {61'd0, req_ack}, 64'b001);
    req_valid = 3'b000;
    tick();
    chk("tmo_rdact", {63'd0, smi_rdact}, 64'd1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (smi_rdact !== 1'b1) bad++;
    end
    chk("tmo_rdact_held", bad, 64'd0);
    tick();
    chk("tmo_rdact_drop", {63'd0, smi_rdact}, 64'd0);
    tick();
    chk("tmo_rsp_valid", {61'd0, rsp_valid}, 64'b001);
    chk("tmo_rsp_err", {63'd0, rsp_err}, 64'd1);
    chk("tmo_rsp_rdata", {48'd0, rsp_rdata}, 64'd0);
    smi_rdata = 16'h0000;
    req_valid = 3'b010;
    tick();
    chk("post_tmo_ack", {61'd0, req_ack}, 64'b010);
    req_valid = 3'b000;
    finish_read(1, 16'h1234);

    // Reset in the middle of a read.
    req_valid = 3'b010;
    tick();
    chk("mid_ack", {61'd0, req_ack}, 64'b010);
    req_valid = 3'b000;
    tick(); tick(); tick();
    rst_100m = 1'b1; req_valid = 3'b101;
    tick();
    chk("mid_reset_zero", {13'd0, req_ack, rsp_valid, rsp_rdata, rsp_err, smi_wract,
        smi_rdact, smi_wdata, smi_dev_addr, smi_phy_addr}, 64'd0);
    tick();
    rst_100m = 1'b0;
    tick();
    chk("post_reset_grant0", {61'd0, req_ack}, 64'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
